// File: rtl/prga_if.sv
`default_nettype none
// ============================================================================
// Module      : prga_if
// Description : Bundle of the ARC4 PRGA stage's handshake and memory ports.
//               slave  - the prga block: accepts en, drives rdy and all
//                        addresses, write data and write enables.
//               master - the sequencer/memory side: drives en and the two
//                        synchronous read-data buses.
// Signals     : en, rdy                     start handshake
//               s_addr/s_rddata/s_wrdata/s_wren   shared S memory port
//               ct_addr/ct_rddata           ciphertext read port
//               pt_addr/pt_wrdata/pt_wren   plaintext write port
// Revision    : 1.0 - initial release
// ============================================================================
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface
`default_nettype wire

// File: rtl/prga.sv
`default_nettype none
// ============================================================================
// Module      : prga
// Description : ARC4 pseudo-random generation stage. Walks the permuted S
//               array, swaps S[i]/S[j] per byte and XORs the keystream byte
//               S[S[i]+S[j]] with a length-prefixed ciphertext (ct[0] = L)
//               to produce plaintext pt[1..L].
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - prga_if.slave: en/rdy handshake, S memory port,
//                        ciphertext read port, plaintext write port
// Options     : PRGA_LEN_ECHO_EN - when defined, pt[0] = L is written before
//               the message bytes (adds one cycle of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module prga (
  input  logic    clk,
  input  logic    rst_n,
  prga_if.slave   bus
);

  localparam logic [3:0] c_IDLE    = 4'd0;
  localparam logic [3:0] c_RD_LEN  = 4'd1;
  localparam logic [3:0] c_CAP_LEN = 4'd2;
`ifdef PRGA_LEN_ECHO_EN
  localparam logic [3:0] c_WR_LEN  = 4'd3;
`endif
  localparam logic [3:0] c_RD_SI   = 4'd4;
  localparam logic [3:0] c_CAP_SI  = 4'd5;
  localparam logic [3:0] c_RD_SJ   = 4'd6;
  localparam logic [3:0] c_CAP_SJ  = 4'd7;
  localparam logic [3:0] c_WR_I    = 4'd8;
  localparam logic [3:0] c_WR_J    = 4'd9;
  localparam logic [3:0] c_RD_PAD  = 4'd10;
  localparam logic [3:0] c_CAP_PAD = 4'd11;
  localparam logic [3:0] c_WR_PT   = 4'd12;
  localparam logic [3:0] c_DONE    = 4'd13;

  logic [3:0] r_state;
  logic [7:0] r_i, r_j, r_k, r_len;
  logic [7:0] r_si, r_sj, r_pad, r_ct;

  logic [7:0] w_s_addr, w_s_wrdata, w_ct_addr, w_pt_addr, w_pt_wrdata;
  logic       w_s_wren, w_pt_wren;

  // Sequential control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_k     <= 8'd0;
      r_len   <= 8'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_pad   <= 8'd0;
      r_ct    <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.en) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= 8'd0;
            r_state <= c_RD_LEN;
          end
        end
        c_RD_LEN: r_state <= c_CAP_LEN;
        c_CAP_LEN: begin
          r_len <= bus.ct_rddata;
`ifdef PRGA_LEN_ECHO_EN
          r_state <= c_WR_LEN;
`else
          // No echo write: branch straight on the freshly read length.
          if (bus.ct_rddata == 8'd0) begin
            r_state <= c_DONE;
          end else begin
            r_k     <= 8'd1;
            r_state <= c_RD_SI;
          end
`endif
        end
`ifdef PRGA_LEN_ECHO_EN
        c_WR_LEN: begin
          if (r_len == 8'd0) begin
            r_state <= c_DONE;
          end else begin
            r_k     <= 8'd1;
            r_state <= c_RD_SI;
          end
        end
`endif
        c_RD_SI: begin
          r_i     <= r_i + 8'd1;
          r_state <= c_CAP_SI;
        end
        c_CAP_SI: begin
          r_si    <= bus.s_rddata;
          r_j     <= r_j + bus.s_rddata;
          r_state <= c_RD_SJ;
        end
        c_RD_SJ:  r_state <= c_CAP_SJ;
        c_CAP_SJ: begin
          r_sj    <= bus.s_rddata;
          r_state <= c_WR_I;
        end
        c_WR_I:   r_state <= c_WR_J;
        c_WR_J:   r_state <= c_RD_PAD;
        c_RD_PAD: r_state <= c_CAP_PAD;
        c_CAP_PAD: begin
          r_pad   <= bus.s_rddata;
          r_ct    <= bus.ct_rddata;
          r_state <= c_WR_PT;
        end
        c_WR_PT: begin
          if (r_k == r_len) begin
            r_state <= c_DONE;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= c_RD_SI;
          end
        end
        c_DONE:   r_state <= c_IDLE;
        default:  r_state <= c_IDLE;
      endcase
    end
  end

  // Memory-port outputs decode from the current state; every output is zero
  // outside the state that uses it, which also yields the reset values.
  always_comb begin
    w_s_addr    = 8'd0;
    w_s_wrdata  = 8'd0;
    w_s_wren    = 1'b0;
    w_ct_addr   = 8'd0;
    w_pt_addr   = 8'd0;
    w_pt_wrdata = 8'd0;
    w_pt_wren   = 1'b0;
    case (r_state)
`ifdef PRGA_LEN_ECHO_EN
      c_WR_LEN: begin
        w_pt_addr   = 8'd0;
        w_pt_wrdata = r_len;
        w_pt_wren   = 1'b1;
      end
`endif
      // r_i is incremented on this same edge, so present the next value now.
      c_RD_SI: w_s_addr = r_i + 8'd1;
      c_RD_SJ: w_s_addr = r_j;
      c_WR_I: begin
        w_s_addr   = r_i;
        w_s_wrdata = r_sj;
        w_s_wren   = 1'b1;
      end
      // When i == j this overwrites the WR_I value at the same address.
      c_WR_J: begin
        w_s_addr   = r_j;
        w_s_wrdata = r_si;
        w_s_wren   = 1'b1;
      end
      c_RD_PAD: begin
        w_s_addr  = r_si + r_sj;
        w_ct_addr = r_k;
      end
      c_WR_PT: begin
        w_pt_addr   = r_k;
        w_pt_wrdata = r_pad ^ r_ct;
        w_pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rdy       = (r_state == c_IDLE);
  assign bus.s_addr    = w_s_addr;
  assign bus.s_wrdata  = w_s_wrdata;
  assign bus.s_wren    = w_s_wren;
  assign bus.ct_addr   = w_ct_addr;
  assign bus.pt_addr   = w_pt_addr;
  assign bus.pt_wrdata = w_pt_wrdata;
  assign bus.pt_wren   = w_pt_wren;

endmodule
`default_nettype wire
